// File: rtl/iomem_router.sv
// iomem_router: routes PicoSoC iomem transactions onto NSLAVE peripheral slots.
// Unmapped or unresponsive slots are terminated with ERR_DATA so the CPU never stalls.
module iomem_router #(
  parameter int          NSLAVE     = 4,
  parameter logic [31:0] BASE       = 32'h0300_0000,
  parameter int          SLOT_SHIFT = 8,
  parameter int          TIMEOUT    = 15,
  parameter logic [31:0] ERR_DATA   = 32'hDEAD_BEEF
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  m_valid,
  output logic                  m_ready,
  input  logic [3:0]            m_wstrb,
  input  logic [31:0]           m_addr,
  input  logic [31:0]           m_wdata,
  output logic [31:0]           m_rdata,
  output logic [NSLAVE-1:0]     s_valid,
  input  logic [NSLAVE-1:0]     s_ready,
  output logic [3:0]            s_wstrb,
  output logic [31:0]           s_addr,
  output logic [31:0]           s_wdata,
  input  logic [32*NSLAVE-1:0]  s_rdata,
  output logic                  err_flag,
  output logic [31:0]           err_addr,
  input  logic                  err_clear
);

  localparam int          SW       = (NSLAVE > 1) ? $clog2(NSLAVE) : 1;
  localparam int          CW       = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [31:0] WIN_MASK = ~((32'(NSLAVE) << SLOT_SHIFT) - 32'd1);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACCESS = 2'd1;
  localparam logic [1:0] S_RESP   = 2'd2;

  logic [1:0]    state;
  logic [SW-1:0] sel_q;
  logic [CW-1:0] count;
  logic          gap;

  logic [SW-1:0] sel;
  logic          hit;
  logic          slot_ready;
  logic [31:0]   slot_rdata;
  logic          timeout;

  assign sel        = m_addr[SLOT_SHIFT +: SW];
  assign hit        = ((m_addr & WIN_MASK) == BASE) && (32'(sel) < 32'(NSLAVE));
  assign slot_ready = s_ready[sel_q];
  assign slot_rdata = s_rdata[32*sel_q +: 32];
  assign timeout    = (count == CW'(TIMEOUT - 1));

  // NOTE: every register here is small control/datapath state, so all of it is
  // cleared by the async reset; a reset mid-access drops s_valid immediately.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state    <= S_IDLE;
      sel_q    <= '0;
      count    <= '0;
      gap      <= 1'b0;
      m_ready  <= 1'b0;
      m_rdata  <= '0;
      s_valid  <= '0;
      s_wstrb  <= '0;
      s_addr   <= '0;
      s_wdata  <= '0;
      err_flag <= 1'b0;
      err_addr <= '0;
    end else begin
      // NOTE: non-blocking assignments throughout; a later error set in the
      // case below overrides this clear, so a simultaneous set wins.
      if (err_clear) err_flag <= 1'b0;

      case (state)
        S_IDLE: begin
          gap <= 1'b0;
          // The cycle right after a response is skipped while the CPU drops valid.
          if (m_valid && !gap) begin
            s_wstrb <= m_wstrb;
            s_addr  <= m_addr;
            s_wdata <= m_wdata;
            sel_q   <= sel;
            if (hit) begin
              s_valid <= NSLAVE'(1) << sel;
              count   <= '0;
              state   <= S_ACCESS;
            end else begin
              m_rdata  <= ERR_DATA;
              err_flag <= 1'b1;
              err_addr <= m_addr;
              state    <= S_RESP;
            end
          end
        end

        S_ACCESS: begin
          if (slot_ready) begin
            m_rdata <= slot_rdata;
            s_valid <= '0;
            m_ready <= 1'b1;
            state   <= S_RESP;
          end else if (timeout) begin
            m_rdata  <= ERR_DATA;
            err_flag <= 1'b1;
            err_addr <= s_addr;
            s_valid  <= '0;
            m_ready  <= 1'b1;
            state    <= S_RESP;
          end else begin
            count <= count + 1'b1;
          end
        end

        S_RESP: begin
          // A miss arrives here with m_ready low and spends one extra cycle.
          if (m_ready) begin
            m_ready <= 1'b0;
            gap     <= 1'b1;
            state   <= S_IDLE;
          end else begin
            m_ready <= 1'b1;
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
